// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// Bit i of req/gnt belongs to requester i (same ordering as selector8 a[0:7]).
interface rr_arbiter8_if;
    logic [0:7] req;
    logic       last;
    logic [2:0] s;
    logic [0:7] gnt;
    logic       valid;

    // requester side
    modport master (output req, output last, input s, input gnt, input valid);
    // arbiter side
    modport slave  (input req, input last, output s, output gnt, output valid);
endinterface

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters sharing one selector8 channel.
// Grants hold until last, a dropped request, or MAXLEN cycles; handover has
// no idle cycle and the finishing requester drops to lowest priority.
module rr_arbiter8 #(
    parameter int MAXLEN = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter8_if.slave bus
);
    localparam int             CW   = $clog2(MAXLEN + 1);
    localparam logic [CW-1:0]  CMAX = CW'(MAXLEN);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [2:0]    p;
    logic [2:0]    s_q;
    logic [CW-1:0] cnt;
    logic [0:7]    gnt_q;
    logic          valid_q;

    logic          grant_end;
    logic [2:0]    p_nxt;
    logic [0:7]    req_m;
    logic [3:0]    win_idle;
    logic [3:0]    win_end;

    // Circular scan from base; returns {found, index}. Walking the offsets
    // downward lets the smallest offset overwrite the result last.
    function automatic logic [3:0] pick(input logic [0:7] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [0:7] onehot(input logic [2:0] i);
        logic [0:7] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // End-of-grant detection and the two winner candidates (fresh / handover).
    always_comb begin
        grant_end = !bus.req[s_q] || bus.last || (cnt == CMAX);
        p_nxt     = s_q + 3'd1;
        req_m     = bus.req;
        if (!bus.req[s_q]) req_m[s_q] = 1'b0;
        win_idle  = pick(bus.req, p);
        win_end   = pick(req_m, p_nxt);
    end

    // Grant FSM; all outputs registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            p       <= '0;
            s_q     <= '0;
            cnt     <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_idle[3]) begin
                        s_q     <= win_idle[2:0];
                        gnt_q   <= onehot(win_idle[2:0]);
                        valid_q <= 1'b1;
                        cnt     <= CW'(1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (grant_end) begin
                        p <= p_nxt;
                        if (win_end[3]) begin
                            s_q   <= win_end[2:0];
                            gnt_q <= onehot(win_end[2:0]);
                            cnt   <= CW'(1);
                        end else begin
                            valid_q <= 1'b0;
                            gnt_q   <= '0;
                            state   <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s     = s_q;
    assign bus.gnt   = gnt_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized bench for rr_arbiter8 against a cycle-level behavioural model.
module tb_rr_arbiter8;
    localparam int MAXLEN = 8;
    localparam int BOUND  = 7 * MAXLEN + 1;

    logic clk;
    logic rst_n;
    rr_arbiter8_if bus();

    rr_arbiter8 #(.MAXLEN(MAXLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    // model state: plain integers, following the grant rules directly
    int m_valid, m_s, m_p, m_cnt;
    int waitc [8];

    task automatic chk(input string tag, input int got, input int exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    endtask

    function automatic logic [0:7] bits(input int a, input int b);
        logic [0:7] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_s = 0; m_p = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) waitc[i] = 0;
    endtask

    // First requester at or after 'from', going round; -1 if none.
    function automatic int first_from(input logic [0:7] r, input int from);
        for (int k = 0; k < 8; k++)
            if (r[(from + k) % 8]) return (from + k) % 8;
        return -1;
    endfunction

    task automatic model_edge(input logic [0:7] r, input logic l);
        int w;
        if (m_valid == 0) begin
            w = first_from(r, m_p);
            if (w >= 0) begin m_valid = 1; m_s = w; m_cnt = 1; end
        end else if (!r[m_s] || l || m_cnt == MAXLEN) begin
            m_p = (m_s + 1) % 8;
            // a dropped requester is already absent from r
            w = first_from(r, m_p);
            if (w >= 0) begin m_s = w; m_cnt = 1; end
            else m_valid = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic compare();
        logic [0:7] eg;
        eg = '0;
        if (m_valid != 0) eg[m_s] = 1'b1;
        chk("valid", int'(bus.valid), m_valid);
        chk("s", int'(bus.s), m_s);
        chk("gnt", int'(bus.gnt), int'(eg));
    endtask

    // One clock: model sees the inputs present at the edge, outputs checked 1ns later.
    task automatic step();
        logic [0:7] r;
        logic       l;
        @(posedge clk);
        r = bus.req;
        l = bus.last;
        model_edge(r, l);
        for (int i = 0; i < 8; i++) begin
            if (m_valid != 0 && m_s == i) begin
                if (waitc[i] > 0) chk("fair", int'(waitc[i] <= BOUND), 1);
                waitc[i] = 0;
            end else if (r[i]) waitc[i]++;
            else waitc[i] = 0;
        end
        #1;
        compare();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        logic [0:7] r;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.last = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_s", int'(bus.s), 0);
        chk("rst_gnt", int'(bus.gnt), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) step();

        // sole requester 5: repeated MAXLEN-long grants with no gap
        bus.req = bits(5, -1);
        repeat (30) step();
        chk("hold_s", int'(bus.s), 5);
        bus.req = '0;
        step();

        // all requesting, last every cycle: 0..7 then 0 again
        do_reset();
        bus.req  = 8'hFF;
        bus.last = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rr_seq", int'(bus.s), i % 8);
        end
        bus.req = '0; bus.last = 1'b0;
        step();

        // pointer: grant to 2 ended by last, then {2,6} -> 6 first, then 2
        bus.req = bits(2, -1);
        step();
        bus.last = 1'b1;
        bus.req  = bits(2, 6);
        step();
        chk("ptr_first", int'(bus.s), 6);
        step();
        chk("ptr_second", int'(bus.s), 2);
        bus.req = '0; bus.last = 1'b0;
        step(); step();

        // early release: 1 drops after 3 grant cycles while 4 waits
        bus.req = bits(1, -1);
        step();
        bus.req = bits(1, 4);
        step(); step();
        bus.req = bits(4, -1);
        step();
        chk("early_s", int'(bus.s), 4);
        bus.req = '0;
        step(); step();

        // randomized traffic with sticky requests
        r = 8'(($urandom));
        for (int c = 0; c < 2500; c++) begin
            r = r ^ 8'($urandom & $urandom & $urandom);
            bus.req  = r;
            bus.last = ($urandom % 6 == 0);
            step();
        end
        bus.req = '0; bus.last = 1'b0;
        step(); step();

        // async reset mid-grant, then 0 beats 3 from the restarted pointer
        bus.req = bits(3, -1);
        step();
        chk("pre_rst_gnt", int'(bus.gnt), int'(bits(3, -1)));
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", int'(bus.valid), 0);
        chk("async_gnt", int'(bus.gnt), 0);
        chk("async_s", int'(bus.s), 0);
        model_reset();
        bus.req = bits(0, 3);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("post_rst_s", int'(bus.s), 0);
        repeat (20) step();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one `selector8` 8:1 channel among eight requesters. It grants the channel to one requester at a time and drives the selector's `s` input with the granted index. It also supplies a one-hot grant vector and a valid flag to the consuming logic. Each grant lasts until the requester finishes, drops its request, or hits a programmable hold limit. It then moves on to the next requester with no idle cycle.

## Interface
- `MAXLEN`, default 8: maximum cycles per grant. Legal range 1..255.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  [0:7]  request lines; bit i belongs to requester i, using the same ordering as selector8 `a[0:7]`.
- `last`  input  1  granted requester flags its final transfer cycle. Ignored when `valid`=0.
- `s`  output  [2:0]  index of the granted requester; connects to selector8 `s`. Registered.
- `gnt`  output  [0:7]  one-hot grant: `gnt[i]` = `valid` & (`s`==i). Registered.
- `valid`  output  1  a grant is active; `s`/`gnt` are meaningful.

## Operation
- Internal state:
  - FSM with states IDLE and BUSY.
  - Priority pointer `p` [2:0].
  - Hold counter `cnt`, width clog2(MAXLEN+1).
- Reset values: `s`=0, `gnt`=0, `valid`=0, `p`=0, `cnt`=0, state IDLE.
- Selection function: scan `req` circularly starting at index `p` (p, p+1, … 7, 0, … p-1). The first asserted bit wins.
- IDLE:
  - If any `req` bit is set, load `s` with the winner, set `valid`=1 and `cnt`=1, and go to BUSY.
  - Otherwise stay in IDLE with outputs unchanged.
- BUSY: the grant ends at the current edge if any of these holds:
  - `req[s]`=0, or
  - `last`=1, or
  - `cnt`==MAXLEN.
- On grant end:
  - Set `p` to `s`+1 mod 8 (7 wraps to 0).
  - Run the selection function on the current `req` using the new `p`. Mask out `req[s]` only when the end cause was `req[s]`=0.
  - If there is a winner, load it into `s`, keep `valid`=1 and set `cnt`=1. This is a back-to-back grant.
  - If there is no winner, set `valid`=0, keep `s` unchanged and go to IDLE.
- BUSY with no end condition: `cnt` increments, and `s`/`gnt` hold.
- No preemption: a new request from another requester never shortens an active grant.
- A requester that still requests at grant end naturally gets lowest priority. It is re-granted immediately only if no other requester is active.
- A transfer cycle is any cycle with `valid`=1 and `req[s]`=1.
- Reset mid-grant: all outputs clear asynchronously, and the in-flight grant is discarded. After reset release the pointer restarts at 0.

## Timing
- Request to grant latency: `req[i]` asserted before edge N gives `valid`/`gnt[i]` after edge N. That is 1 cycle from IDLE.
- Grant length: 1..MAXLEN cycles. `last` or a dropped `req` in grant cycle k ends the grant after k cycles.
- Handover: zero bubble. The new `s` is valid in the cycle immediately after the old grant's final cycle.
- Fairness bound: a continuously requesting requester is granted within 7*MAXLEN+1 cycles.
- Outputs change only on `clk` rising edges, except for the asynchronous clear on `rst_n` falling.
- `last` and `req` are sampled only at rising edges. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst_n`=0 → `s`=0, `gnt`=0, `valid`=0. Release with `req`=0 for 5 cycles → outputs stay 0.
- Hold limit: MAXLEN=8, only `req[5]` held, `last`=0.
  - `gnt[5]`=1 and `s`=5 from the cycle after the request, continuously. `cnt` wraps to 1 every 8 cycles.
  - `valid` never drops, because the sole requester is re-granted with zero bubble.
- Round-robin: all `req`=1, `last`=1 every cycle → `s` sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles. `valid` stays 1.
- Pointer priority: with `p`=3 (after a grant to 2 ends), assert `req[2]` and `req[6]` → 6 is granted first. When it ends with `last`, 2 is granted on the next cycle.
- Early release: `req[1]` granted, drops after 3 grant cycles while `req[4]`=1 → `gnt[4]` appears in the cycle right after `req[1]`'s last grant cycle, and `p` becomes 2.
- Async reset mid-grant: `gnt[3]` active, pull `rst_n` low between edges → outputs are 0 before the next edge. After release with `req[0]` and `req[3]` both set → 0 is granted first.
